// File: rtl/sm2_arith_pkg.sv
// rtl/sm2_arith_pkg.sv - shared moduli, default widths and FSM encoding for the modular arithmetic blocks
package sm2_arith_pkg;

    localparam int DEF_WIDTH  = 256;
    localparam int DEF_LIMB_W = 64;

    localparam logic [255:0] SM2_P =
        256'hfffffffe_ffffffff_ffffffff_ffffffff_ffffffff_00000000_ffffffff_ffffffff;
    localparam logic [255:0] NIST_P =
        256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_ffffffff;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/limb_addsub.sv
// rtl/limb_addsub.sv - one limb of add-then-subtract (or subtract-then-add) with carry and borrow chains
module limb_addsub #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] x,
    input  logic [LIMB_W-1:0] y,
    input  logic [LIMB_W-1:0] m,
    input  logic              cin,
    input  logic              bin,
    input  logic              sub,
    output logic [LIMB_W-1:0] s,
    output logic [LIMB_W-1:0] d,
    output logic              cout,
    output logic              bout
);

    logic [LIMB_W:0] first;
    logic [LIMB_W:0] second;

    // One extra bit holds the carry, or flags the borrow when the difference wraps.
    always_comb begin
        first  = '0;
        second = '0;
        if (sub) begin
            first  = {1'b0, x} - {1'b0, y} - {{LIMB_W{1'b0}}, bin};
            second = {1'b0, first[LIMB_W-1:0]} + {1'b0, m} + {{LIMB_W{1'b0}}, cin};
        end else begin
            first  = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};
            second = {1'b0, first[LIMB_W-1:0]} - {1'b0, m} - {{LIMB_W{1'b0}}, bin};
        end
    end

    assign s    = first[LIMB_W-1:0];
    assign d    = second[LIMB_W-1:0];
    assign cout = sub ? second[LIMB_W] : first[LIMB_W];
    assign bout = sub ? first[LIMB_W]  : second[LIMB_W];

endmodule

// File: rtl/mod_add_seq.sv
// rtl/mod_add_seq.sv - limb-serial modular adder res=(a+b) mod p; MOD_ADD_SUB_OP_EN adds an op port for subtract
module mod_add_seq
    import sm2_arith_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LIMB_W = DEF_LIMB_W
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MOD_ADD_SUB_OP_EN
    input  logic             op,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);

    localparam int NUM_LIMBS = WIDTH / LIMB_W;
    localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

    state_t             state;
    logic [CNT_W-1:0]   limb_cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   p_sh;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   diff_q;
    logic               carry;
    logic               borrow;
    logic               sub_q;
    logic [LIMB_W-1:0]  s_limb;
    logic [LIMB_W-1:0]  d_limb;
    logic               carry_nxt;
    logic               borrow_nxt;
    logic               take_diff;

    limb_addsub #(.LIMB_W(LIMB_W)) u_limb (
        .x    (a_sh[LIMB_W-1:0]),
        .y    (b_sh[LIMB_W-1:0]),
        .m    (p_sh[LIMB_W-1:0]),
        .cin  (carry),
        .bin  (borrow),
        .sub  (sub_q),
        .s    (s_limb),
        .d    (d_limb),
        .cout (carry_nxt),
        .bout (borrow_nxt)
    );

    // A carry out of the sum means it already exceeds p, so the reduced value wins.
    assign take_diff = sub_q ? borrow : (carry | ~borrow);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            limb_cnt  <= '0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
            sub_q     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            p_sh      <= '0;
            sum_q     <= '0;
            diff_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        p_sh     <= p;
`ifdef MOD_ADD_SUB_OP_EN
                        sub_q    <= op;
`else
                        sub_q    <= 1'b0;
`endif
                        carry    <= 1'b0;
                        borrow   <= 1'b0;
                        limb_cnt <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_sh     <= a_sh >> LIMB_W;
                    b_sh     <= b_sh >> LIMB_W;
                    p_sh     <= p_sh >> LIMB_W;
                    sum_q    <= {s_limb, sum_q[WIDTH-1:LIMB_W]};
                    diff_q   <= {d_limb, diff_q[WIDTH-1:LIMB_W]};
                    carry    <= carry_nxt;
                    borrow   <= borrow_nxt;
                    limb_cnt <= limb_cnt + 1'b1;
                    if (limb_cnt == CNT_W'(NUM_LIMBS - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        res       <= take_diff ? diff_q : sum_q;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
